// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM state encoding and default frame timing.
package uart_pkg;

  localparam int unsigned DefaultWidth      = 8;
  localparam int unsigned DefaultClksPerBit = 1736;  // 57600 baud at 100 MHz

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t StIdle    = 3'd0;
  localparam uart_state_t StStart   = 3'd1;
  localparam uart_state_t StData    = 3'd2;
  localparam uart_state_t StParity  = 3'd3;
  localparam uart_state_t StStop    = 3'd4;
  localparam uart_state_t StRecover = 3'd5;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to ResetValue.
module uart_sync #(
  parameter logic ResetValue = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetValue;
      sync_q <= ResetValue;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 1 start, WIDTH data bits LSB first, 1 stop, mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data and a parity_err output.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH        = DefaultWidth,
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             frame_err,
  output logic             busy,
  output logic [3:0]       bit_count
`ifdef UART_RX_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int unsigned TimerW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TimerW-1:0] LastTick = TimerW'(CLKS_PER_BIT - 1);
  localparam logic [TimerW-1:0] HalfTick = TimerW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]        LastBit  = 4'(WIDTH - 1);

  logic              rx_sync;
  logic              rx_prev_q;
  uart_state_t       state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic              par_q, par_d;
  logic              perr_q, perr_d;
`endif

  uart_sync #(
    .ResetValue(1'b1)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(reset),
    .d_i   (rx),
    .q_o   (rx_sync)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        timer_d   = '0;
        bit_cnt_d = '0;
        if (rx_prev_q && !rx_sync) state_d = StStart;
      end
      StStart: begin
        if (timer_q == HalfTick) begin
          timer_d = '0;
          state_d = rx_sync ? StIdle : StData;  // high at mid-start is a glitch
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StData: begin
        if (timer_q == LastTick) begin
          timer_d = '0;
          shift_d = {rx_sync, shift_q[WIDTH-1:1]};
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = StParity;
`else
            state_d   = StStop;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (timer_q == LastTick) begin
          timer_d = '0;
          par_d   = rx_sync;
          state_d = StStop;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`endif
      StStop: begin
        if (timer_q == LastTick) begin
          timer_d = '0;
          if (rx_sync) begin
            data_d  = shift_q;
            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = (^shift_q) ^ par_q;
`endif
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StRecover;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StRecover: begin
        // Hold here through a break so it reports only one frame error.
        timer_d = '0;
        if (rx_sync) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_prev_q <= 1'b1;
      state_q   <= StIdle;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      rx_prev_q <= rx_sync;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != StIdle);
  assign bit_count = bit_cnt_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule
